seq_muldiv: RTL and testbench

SEQ_MULDIV -- requirements
Module: seq_muldiv

---
 rtl/seq_muldiv.sv | 194 +++++++++++++++++++
 tb/tb_seq_muldiv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// Sequential signed multiply/divide: shift-add multiply or restoring divide, one bit per cycle.
// Divide support is compiled in only when SEQ_MULDIV_DIV_EN is defined.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               muordi,
  input  logic [WIDTH-1:0]   opera1,
  input  logic [WIDTH-1:0]   opera2,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               busy,
  output logic               dbz
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               sign1_q, sign1_d, sign2_q, sign2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               valid_q, valid_d, busy_q, busy_d;

  logic               last_cnt;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step, mul_fix;

  assign last_cnt = (cnt_q == CntW'(WIDTH - 1));
  // Unsigned negation maps the most-negative value onto 2^(WIDTH-1) exactly.
  assign mag1 = opera1[WIDTH-1] ? -opera1 : opera1;
  assign mag2 = opera2[WIDTH-1] ? -opera2 : opera2;

  // p_q holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_step = {mul_sum, p_q[WIDTH-1:1]};
  assign mul_fix  = (sign1_q ^ sign2_q) ? -p_q : p_q;

`ifdef SEQ_MULDIV_DIV_EN
  logic               div_q, div_d, dbzf_q, dbzf_d, dbz_q, dbz_d;
  logic               div_zero, div_ge;
  logic [WIDTH:0]     div_trial, div_diff;
  logic [2*WIDTH-1:0] div_step, div_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign div_zero = muordi && (opera2 == '0);
  // p_q holds {partial remainder, dividend bits shifting into quotient bits}.
  assign div_trial = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, m_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_step  = {div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0], p_q[WIDTH-2:0], div_ge};
  assign quo_fix   = (sign1_q ^ sign2_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem_fix   = sign1_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  assign div_fix   = {rem_fix, quo_fix};
  assign dbz       = dbz_q;
`else
  logic unused_muordi;
  assign unused_muordi = muordi;
  assign dbz           = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
`ifdef SEQ_MULDIV_DIV_EN
          state_d = div_zero ? StDone : StCalc;
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc:  if (last_cnt) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d    = cnt_q;
    m_d      = m_q;
    p_d      = p_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
`ifdef SEQ_MULDIV_DIV_EN
    div_d    = div_q;
    dbzf_d   = dbzf_q;
    dbz_d    = dbz_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = '0;
          sign1_d = opera1[WIDTH-1];
          sign2_d = opera2[WIDTH-1];
          busy_d  = 1'b1;
          m_d     = mag1;
          p_d     = {{WIDTH{1'b0}}, mag2};
`ifdef SEQ_MULDIV_DIV_EN
          div_d  = muordi;
          dbzf_d = div_zero;
          if (div_zero) begin
            p_d = {opera1, {WIDTH{1'b1}}};
          end else if (muordi) begin
            m_d = mag2;
            p_d = {{WIDTH{1'b0}}, mag1};
          end
`endif
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        p_d   = mul_step;
`ifdef SEQ_MULDIV_DIV_EN
        if (div_q) p_d = div_step;
`endif
      end
      StFix: begin
        p_d = mul_fix;
`ifdef SEQ_MULDIV_DIV_EN
        if (div_q) p_d = div_fix;
`endif
      end
      StDone: begin
        result_d = p_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
        dbz_d    = dbzf_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      m_q      <= '0;
      p_q      <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
      div_q    <= 1'b0;
      dbzf_q   <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      p_q      <= p_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef SEQ_MULDIV_DIV_EN
      div_q    <= div_d;
      dbzf_q   <= dbzf_d;
      dbz_q    <= dbz_d;
`endif
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Bench for seq_muldiv: vector table plus random model checks through a scoreboard queue,
// and hand sequences for start-while-busy, mid-operation reset and result hold.
module tb_seq_muldiv;

  localparam int unsigned W = 32;

  logic           clock, reset, start, muordi;
  logic [W-1:0]   opera1, opera2;
  logic [2*W-1:0] result;
  logic           valid, busy, dbz;

  seq_muldiv #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .muordi (muordi),
    .opera1 (opera1),
    .opera2 (opera2),
    .result (result),
    .valid  (valid),
    .busy   (busy),
    .dbz    (dbz)
  );

  typedef struct {
    logic           op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    logic           exp_dbz;
    int             exp_lat;
  } vec_t;

  vec_t           vecs[$];
  vec_t           exp_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  logic [2*W-1:0] last_exp = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] exp, input logic exp_dbz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.exp_dbz = exp_dbz; v.exp_lat = lat;
    return v;
  endfunction

  function automatic vec_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t   v;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v = mk(op, a, b, '0, 1'b0, W + 2);
`ifdef SEQ_MULDIV_DIV_EN
    if (op) begin
      if (b == '0) begin
        v.exp = {a, {W{1'b1}}}; v.exp_dbz = 1'b1; v.exp_lat = 1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        v.exp = {r[W-1:0], q[W-1:0]};
      end
      return v;
    end
`endif
    v.exp = sa * sb;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    exp_q.push_back(v);
    muordi = v.op; opera1 = v.a; opera2 = v.b; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic await_result(input int start_lat);
    int   lat;
    logic got;
    vec_t v;
    lat = start_lat;
    got = 1'b0;
    while (!got && lat < 200) begin
      tick();
      lat++;
      got = valid;
    end
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got result with no expectation queued, required one");
    end else begin
      v = exp_q.pop_front();
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL valid_timeout: got no valid in 200 cycles, required latency %0d", v.exp_lat);
      end else begin
        check("result", result, v.exp);
        check("dbz", 64'(dbz), 64'(v.exp_dbz));
        check("latency", 64'(lat), 64'(v.exp_lat));
        last_exp = v.exp;
      end
    end
  endtask

  task automatic run_op(input vec_t v);
    issue(v);
    await_result(0);
  endtask

  initial begin
    int   nvalid;
    logic [W-1:0] ra, rb;

    reset = 1'b0; start = 1'b0; muordi = 1'b0; opera1 = '0; opera2 = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_dbz", 64'(dbz), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    vecs.push_back(mk(1'b0, 32'd2, 32'd32, 64'd64, 1'b0, 34));
    vecs.push_back(mk(1'b0, 32'hFFFFFFFE, 32'd32, 64'hFFFFFFFFFFFFFFC0, 1'b0, 34));
    vecs.push_back(mk(1'b0, 32'd2, 32'hFFFFFFE0, 64'hFFFFFFFFFFFFFFC0, 1'b0, 34));
    vecs.push_back(mk(1'b0, 32'hFFFFFFFE, 32'hFFFFFFE0, 64'd64, 1'b0, 34));
    vecs.push_back(mk(1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 34));
    vecs.push_back(mk(1'b0, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, 1'b0, 34));
`ifdef SEQ_MULDIV_DIV_EN
    vecs.push_back(mk(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFFFFFFFFFD, 1'b0, 34));
    vecs.push_back(mk(1'b1, 32'd100, 32'd0, 64'h00000064FFFFFFFF, 1'b1, 1));
    vecs.push_back(mk(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1'b0, 34));
    vecs.push_back(mk(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001FFFFFFFD, 1'b0, 34));
    vecs.push_back(mk(1'b1, 32'd100, 32'd7, 64'h000000020000000E, 1'b0, 34));
`else
    vecs.push_back(mk(1'b1, 32'd6, 32'd3, 64'd18, 1'b0, 34));
    vecs.push_back(mk(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFFFFFFFFF2, 1'b0, 34));
    vecs.push_back(mk(1'b1, 32'd100, 32'd0, 64'd0, 1'b0, 34));
`endif
    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = $urandom();
      vecs.push_back(model(1'b0, ra, rb));
      rb = (i < 3) ? W'($urandom_range(1, 1000)) : $urandom();
      if (rb == '0) rb = 1;
      if (i % 2 == 1) rb = -rb;
      vecs.push_back(model(1'b1, ra, rb));
    end

    // Operations are issued back-to-back: each start lands in the previous valid cycle.
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) check("valid_one_cycle", 64'(valid), 64'd0);
    end
    check("result_hold", result, last_exp);

    // Start pulsed mid-operation must be ignored.
    issue(mk(1'b0, 32'd2, 32'd32, 64'd64, 1'b0, 34));
    for (int i = 0; i < 4; i++) tick();
    muordi = 1'b0; opera1 = 32'd3; opera2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ignored_start", 64'(busy), 64'd1);
    await_result(5);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid) nvalid++;
    end
    check("no_extra_valid", 64'(nvalid), 64'd0);

    // Reset asserted mid-operation aborts it.
    muordi = 1'b0; opera1 = 32'd6; opera2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    tick(); tick();
    reset = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid) nvalid++;
    end
    check("abort_no_valid", 64'(nvalid), 64'd0);

    run_op(mk(1'b0, 32'hFFFFFFFE, 32'hFFFFFFE0, 64'd64, 1'b0, 34));
`ifdef SEQ_MULDIV_DIV_EN
    run_op(mk(1'b1, 32'd100, 32'd0, 64'h00000064FFFFFFFF, 1'b1, 1));
`else
    run_op(mk(1'b1, 32'd6, 32'd3, 64'd18, 1'b0, 34));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
